// File: rtl/cache_pkg.sv
// Shared constants for the cache management FSM: address field layout,
// state encoding, load/store width codes and the line-word address helper.
package cache_pkg;

    localparam int ADDR_BITS       = 32;
    localparam int TAG_BITS        = 23;
    localparam int SET_INDEX_WIDTH = 5;
    localparam int WORD_SEL_WIDTH  = 2;
    localparam int BYTE_SEL_WIDTH  = 2;
    localparam int LINE_WORDS      = 4;

    localparam int WORD_LSB  = BYTE_SEL_WIDTH;
    localparam int INDEX_LSB = WORD_LSB + WORD_SEL_WIDTH;
    localparam int TAG_LSB   = INDEX_LSB + SET_INDEX_WIDTH;

    localparam logic [WORD_SEL_WIDTH-1:0] LAST_WORD = WORD_SEL_WIDTH'(LINE_WORDS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CHECK    = 3'd1;
    localparam logic [2:0] S_PRE_BACK = 3'd2;
    localparam logic [2:0] S_BACK     = 3'd3;
    localparam logic [2:0] S_FILL     = 3'd4;
    localparam logic [2:0] S_WAIT     = 3'd5;

    localparam logic [2:0] UBHW_B  = 3'b000;
    localparam logic [2:0] UBHW_H  = 3'b001;
    localparam logic [2:0] UBHW_W  = 3'b010;
    localparam logic [2:0] UBHW_BU = 3'b100;
    localparam logic [2:0] UBHW_HU = 3'b101;

    function automatic logic [ADDR_BITS-1:0] line_word_addr(
        input logic [TAG_BITS-1:0]        tag,
        input logic [SET_INDEX_WIDTH-1:0] index,
        input logic [WORD_SEL_WIDTH-1:0]  word
    );
        line_word_addr = {tag, index, word, {BYTE_SEL_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_ctrl.sv
// Cache management FSM: lookup/stall sequencing, dirty-victim writeback and
// 4-word line refill between the CPU memory stage and a 2-way data cache.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_BITS-1:0]  addr_rw,
    input  logic                  en_r,
    input  logic                  en_w,
    input  logic [2:0]            u_b_h_w,
    input  logic [31:0]           data_w,
    output logic [31:0]           data_r,
    output logic                  stall,
    output logic [ADDR_BITS-1:0]  cache_addr,
    output logic                  cache_load,
    output logic                  cache_store,
    output logic                  cache_edit,
    output logic                  cache_invalid,
    output logic [31:0]           cache_din,
    output logic [2:0]            cache_u_b_h_w,
    input  logic                  cache_hit,
    input  logic [31:0]           cache_dout,
    input  logic                  cache_valid,
    input  logic                  cache_dirty,
    input  logic [TAG_BITS-1:0]   cache_tag,
    output logic                  mem_cs_o,
    output logic                  mem_we_o,
    output logic [ADDR_BITS-1:0]  mem_addr_o,
    output logic [31:0]           mem_data_o,
    input  logic [31:0]           mem_data_i,
    input  logic                  mem_ack_i
);

    logic [2:0]                 state_r;
    logic [WORD_SEL_WIDTH-1:0]  word_cnt_r;
    logic [TAG_BITS-1:0]        victim_tag_r;
    logic [ADDR_BITS-1:0]       req_addr_r;

    logic                       req_s;
    logic [TAG_BITS-1:0]        req_tag_s;
    logic [SET_INDEX_WIDTH-1:0] req_index_s;
    logic [ADDR_BITS-1:0]       fill_addr_s;
    logic [ADDR_BITS-1:0]       back_addr_s;
    logic [ADDR_BITS-1:0]       victim_rd_addr_s;
    logic [ADDR_BITS-1:0]       set_addr_s;

    // The miss address is latched so a request dropped mid-miss still refills the right line.
    assign req_s            = en_r | en_w;
    assign req_tag_s        = req_addr_r[ADDR_BITS-1:TAG_LSB];
    assign req_index_s      = req_addr_r[TAG_LSB-1:INDEX_LSB];
    assign fill_addr_s      = line_word_addr(req_tag_s, req_index_s, word_cnt_r);
    assign back_addr_s      = line_word_addr(victim_tag_r, req_index_s, word_cnt_r);
    assign victim_rd_addr_s = line_word_addr({TAG_BITS{1'b0}}, req_index_s, word_cnt_r);
    assign set_addr_s       = line_word_addr(req_tag_s, req_index_s, {WORD_SEL_WIDTH{1'b0}});

    assign stall = req_s & ~((state_r == S_CHECK) & cache_hit);

    // Cache strobes and memory port, decoded from the current state.
    always_comb begin
        cache_addr    = addr_rw;
        cache_load    = 1'b0;
        cache_store   = 1'b0;
        cache_edit    = 1'b0;
        cache_invalid = 1'b0;
        cache_din     = data_w;
        cache_u_b_h_w = u_b_h_w;
        mem_cs_o      = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = fill_addr_s;
        mem_data_o    = cache_dout;
        if (!rst) begin
            // A reset landing mid-refill or mid-writeback must not leave a partial line valid.
            if ((state_r == S_FILL) || (state_r == S_BACK)) begin
                cache_invalid = 1'b1;
                cache_addr    = set_addr_s;
            end else begin
                cache_invalid = 1'b0;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    cache_load = en_r & ~en_w;
                    cache_edit = en_w;
                end
                S_CHECK: begin
                    cache_addr = req_addr_r;
                end
                S_PRE_BACK: begin
                    cache_addr = victim_rd_addr_s;
                end
                S_BACK: begin
                    cache_addr = victim_rd_addr_s;
                    mem_cs_o   = 1'b1;
                    mem_we_o   = 1'b1;
                    mem_addr_o = back_addr_s;
                end
                S_FILL: begin
                    mem_cs_o   = 1'b1;
                    mem_addr_o = fill_addr_s;
                    cache_addr = fill_addr_s;
                    if (mem_ack_i) begin
                        cache_store = 1'b1;
                        cache_din   = mem_data_i;
                    end else begin
                        cache_store = 1'b0;
                    end
                end
                S_WAIT: begin
                    cache_addr = addr_rw;
                end
                default: begin
                    cache_addr = addr_rw;
                end
            endcase
        end
    end

    // State, word counter, captured victim tag, miss address and CPU load data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            word_cnt_r   <= {WORD_SEL_WIDTH{1'b0}};
            victim_tag_r <= {TAG_BITS{1'b0}};
            req_addr_r   <= {ADDR_BITS{1'b0}};
            data_r       <= 32'h0000_0000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req_s) begin
                        req_addr_r <= addr_rw;
                        state_r    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cache_hit) begin
                        if (en_r && !en_w) begin
                            data_r <= cache_dout;
                        end
                        state_r <= S_IDLE;
                    end else begin
                        victim_tag_r <= cache_tag;
                        word_cnt_r   <= {WORD_SEL_WIDTH{1'b0}};
                        state_r      <= (cache_valid && cache_dirty) ? S_PRE_BACK : S_FILL;
                    end
                end
                S_PRE_BACK: begin
                    state_r <= S_BACK;
                end
                S_BACK: begin
                    if (mem_ack_i) begin
                        word_cnt_r <= word_cnt_r + 2'd1;
                        state_r    <= (word_cnt_r == LAST_WORD) ? S_FILL : S_PRE_BACK;
                    end
                end
                S_FILL: begin
                    if (mem_ack_i) begin
                        word_cnt_r <= word_cnt_r + 2'd1;
                        if (word_cnt_r == LAST_WORD) begin
                            state_r <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural 2-way cache and a
// fixed-latency word memory wrapped around the controller.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr_rw = 32'h0;
    logic        en_r = 1'b0;
    logic        en_w = 1'b0;
    logic [2:0]  u_b_h_w = 3'b010;
    logic [31:0] data_w = 32'h0;
    logic [31:0] data_r;
    logic        stall;
    logic [31:0] cache_addr;
    logic        cache_load, cache_store, cache_edit, cache_invalid;
    logic [31:0] cache_din;
    logic [2:0]  cache_u_b_h_w;
    logic        cache_hit = 1'b0;
    logic [31:0] cache_dout = 32'h0;
    logic        cache_valid = 1'b0;
    logic        cache_dirty = 1'b0;
    logic [22:0] cache_tag = 23'h0;
    logic        mem_cs_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [31:0] mem_data_i = 32'h0;
    logic        mem_ack_i = 1'b0;

    cache_ctrl dut (
        .clk(clk), .rst(rst), .addr_rw(addr_rw), .en_r(en_r), .en_w(en_w),
        .u_b_h_w(u_b_h_w), .data_w(data_w), .data_r(data_r), .stall(stall),
        .cache_addr(cache_addr), .cache_load(cache_load), .cache_store(cache_store),
        .cache_edit(cache_edit), .cache_invalid(cache_invalid), .cache_din(cache_din),
        .cache_u_b_h_w(cache_u_b_h_w), .cache_hit(cache_hit), .cache_dout(cache_dout),
        .cache_valid(cache_valid), .cache_dirty(cache_dirty), .cache_tag(cache_tag),
        .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural 2-way cache ----------------
    logic        model_clear = 1'b1;
    logic [22:0] tag_m   [32][2];
    logic        valid_m [32][2];
    logic        dirty_m [32][2];
    logic [31:0] data_m  [32][2][4];
    logic        lru_m   [32];

    logic [4:0]  m_idx;
    logic [22:0] m_tag;
    logic [1:0]  m_word;
    logic        m_hit, m_hw, m_vw, m_rw;
    logic [31:0] m_old, m_new;

    always_comb begin
        m_idx  = cache_addr[8:4];
        m_tag  = cache_addr[31:9];
        m_word = cache_addr[3:2];
        m_hit  = 1'b0;
        m_hw   = 1'b0;
        if (valid_m[m_idx][0] && tag_m[m_idx][0] == m_tag) begin
            m_hit = 1'b1;
            m_hw  = 1'b0;
        end else if (valid_m[m_idx][1] && tag_m[m_idx][1] == m_tag) begin
            m_hit = 1'b1;
            m_hw  = 1'b1;
        end
        m_vw  = lru_m[m_idx];
        m_rw  = m_hit ? m_hw : m_vw;
        m_old = data_m[m_idx][m_rw][m_word];
        m_new = m_old;
        case (cache_u_b_h_w[1:0])
            2'b00:   m_new[cache_addr[1:0]*8 +: 8]     = cache_din[7:0];
            2'b01:   m_new[cache_addr[1]*16 +: 16]     = cache_din[15:0];
            default: m_new                             = cache_din;
        endcase
    end

    always @(posedge clk) begin
        cache_hit   <= m_hit;
        cache_dout  <= m_old;
        cache_valid <= valid_m[m_idx][m_vw];
        cache_dirty <= dirty_m[m_idx][m_vw];
        cache_tag   <= tag_m[m_idx][m_vw];
        if (model_clear) begin
            for (int s = 0; s < 32; s++) begin
                lru_m[s] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    valid_m[s][w] <= 1'b0;
                    dirty_m[s][w] <= 1'b0;
                    tag_m[s][w]   <= 23'h0;
                end
            end
        end else if (cache_invalid) begin
            valid_m[m_idx][0] <= 1'b0;
            valid_m[m_idx][1] <= 1'b0;
            dirty_m[m_idx][0] <= 1'b0;
            dirty_m[m_idx][1] <= 1'b0;
        end else if (cache_store) begin
            if (!m_hit) begin
                tag_m[m_idx][m_vw]   <= m_tag;
                valid_m[m_idx][m_vw] <= 1'b1;
                dirty_m[m_idx][m_vw] <= 1'b0;
            end
            data_m[m_idx][m_rw][m_word] <= cache_din;
            lru_m[m_idx] <= ~m_rw;
        end else if (cache_edit && m_hit) begin
            data_m[m_idx][m_hw][m_word] <= m_new;
            dirty_m[m_idx][m_hw] <= 1'b1;
            lru_m[m_idx] <= ~m_hw;
        end else if (cache_load && m_hit) begin
            lru_m[m_idx] <= ~m_hw;
        end
    end

    // ---------------- word memory, 3-cycle ack latency ----------------
    logic [31:0] mem_arr     [1024];
    logic        mem_written [1024];
    int          lat_cnt = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic        log_we[$];
    int          store_cnt = 0;
    int          cs_cycles = 0;
    int          excl_viol = 0;

    function automatic logic [31:0] mem_default(input logic [9:0] wi);
        logic [31:0] a;
        a = {20'h0, wi, 2'b00};
        case (a)
            32'h100: mem_default = 32'h11;
            32'h104: mem_default = 32'h22;
            32'h108: mem_default = 32'h33;
            32'h10C: mem_default = 32'h44;
            default: mem_default = 32'hC000_0000 | a;
        endcase
    endfunction

    always @(posedge clk) begin
        mem_ack_i <= 1'b0;
        if (model_clear) begin
            for (int i = 0; i < 1024; i++) mem_written[i] <= 1'b0;
            lat_cnt <= 0;
        end else if (mem_cs_o && !mem_ack_i) begin
            if (lat_cnt == 2) begin
                lat_cnt   <= 0;
                mem_ack_i <= 1'b1;
                log_addr.push_back(mem_addr_o);
                log_we.push_back(mem_we_o);
                if (mem_we_o) begin
                    mem_arr[mem_addr_o[11:2]]     <= mem_data_o;
                    mem_written[mem_addr_o[11:2]] <= 1'b1;
                    log_data.push_back(mem_data_o);
                end else begin
                    mem_data_i <= mem_written[mem_addr_o[11:2]] ? mem_arr[mem_addr_o[11:2]]
                                                                : mem_default(mem_addr_o[11:2]);
                    log_data.push_back(32'h0);
                end
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            lat_cnt <= 0;
        end
        if (cache_store) store_cnt <= store_cnt + 1;
        if (mem_cs_o) cs_cycles <= cs_cycles + 1;
        if (32'(cache_store) + 32'(cache_edit) + 32'(cache_load) > 32'd1) excl_viol <= excl_viol + 1;
    end

    // ---------------- CPU access helper ----------------
    task automatic cpu_access(input logic [31:0] a, input logic rd, input logic wr,
                              input logic [2:0] code, input logic [31:0] wd,
                              output int cyc, output logic edit0, output logic load0);
        @(negedge clk);
        addr_rw = a; en_r = rd; en_w = wr; u_b_h_w = code; data_w = wd;
        #1;
        edit0 = cache_edit;
        load0 = cache_load;
        cyc   = 0;
        while (stall && cyc < 500) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        check_eq("access_done", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        en_r = 1'b0;
        en_w = 1'b0;
    endtask

    logic [31:0] exp_wb [4] = '{32'h11, 32'h22, 32'h0000_AB33, 32'h44};

    initial begin
        int   cyc, s0, c0, n;
        logic e0, l0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_cs", 32'(mem_cs_o), 32'd0);
        check_eq("rst_data_r", data_r, 32'd0);
        check_eq("rst_strobes", {28'h0, cache_load, cache_edit, cache_store, cache_invalid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_clear = 1'b0;

        // cold LW 0x104: 4 fill reads, no writeback
        log_addr.delete(); log_data.delete(); log_we.delete();
        s0 = store_cnt;
        cpu_access(32'h104, 1'b1, 1'b0, 3'b010, 32'h0, cyc, e0, l0);
        check_eq("cold_load_strobe", 32'(l0), 32'd1);
        check_eq("cold_data", data_r, 32'h22);
        check_eq("cold_stall_cyc", 32'(cyc), 32'd20);
        check_eq("cold_stores", 32'(store_cnt - s0), 32'd4);
        check_eq("cold_nreq", 32'(log_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("cold_addr", log_addr[i], 32'h100 + 32'(4 * i));
            check_eq("cold_we", 32'(log_we[i]), 32'd0);
        end

        // LW 0x108 hits: one stall cycle, no memory traffic
        c0 = cs_cycles;
        cpu_access(32'h108, 1'b1, 1'b0, 3'b010, 32'h0, cyc, e0, l0);
        check_eq("hit_stall_cyc", 32'(cyc), 32'd1);
        check_eq("hit_data", data_r, 32'h33);
        check_eq("hit_no_mem", 32'(cs_cycles - c0), 32'd0);

        // SB 0x109 then LW 0x108
        cpu_access(32'h109, 1'b0, 1'b1, 3'b000, 32'hAB, cyc, e0, l0);
        check_eq("sb_edit", 32'(e0), 32'd1);
        check_eq("sb_load", 32'(l0), 32'd0);
        cpu_access(32'h108, 1'b1, 1'b0, 3'b010, 32'h0, cyc, e0, l0);
        check_eq("sb_readback", data_r, 32'h0000_AB33);

        // fill second way, dirty it, then evict the dirty first way
        log_addr.delete(); log_data.delete(); log_we.delete();
        cpu_access(32'h304, 1'b1, 1'b0, 3'b010, 32'h0, cyc, e0, l0);
        check_eq("way2_data", data_r, 32'hC000_0304);
        check_eq("way2_stall_cyc", 32'(cyc), 32'd20);
        cpu_access(32'h300, 1'b0, 1'b1, 3'b010, 32'hDEAD, cyc, e0, l0);
        check_eq("sw_stall_cyc", 32'(cyc), 32'd1);
        log_addr.delete(); log_data.delete(); log_we.delete();
        cpu_access(32'h504, 1'b1, 1'b0, 3'b010, 32'h0, cyc, e0, l0);
        check_eq("evict_stall_cyc", 32'(cyc), 32'd40);
        check_eq("evict_nreq", 32'(log_addr.size()), 32'd8);
        for (int i = 0; i < 4; i++) begin
            check_eq("wb_we", 32'(log_we[i]), 32'd1);
            check_eq("wb_addr", log_addr[i], 32'h100 + 32'(4 * i));
            check_eq("wb_data", log_data[i], exp_wb[i]);
            check_eq("refill_we", 32'(log_we[i + 4]), 32'd0);
            check_eq("refill_addr", log_addr[i + 4], 32'h500 + 32'(4 * i));
        end
        check_eq("evict_data", data_r, 32'hC000_0504);

        // en_r and en_w together on a hit: treated as a write
        cpu_access(32'h500, 1'b1, 1'b1, 3'b010, 32'h5566_7788, cyc, e0, l0);
        check_eq("rw_edit", 32'(e0), 32'd1);
        check_eq("rw_load", 32'(l0), 32'd0);
        check_eq("rw_stall_cyc", 32'(cyc), 32'd1);
        check_eq("rw_data_r_kept", data_r, 32'hC000_0504);
        cpu_access(32'h500, 1'b1, 1'b0, 3'b010, 32'h0, cyc, e0, l0);
        check_eq("rw_readback", data_r, 32'h5566_7788);

        // reset in the middle of a refill
        @(negedge clk);
        addr_rw = 32'h040; en_r = 1'b1; en_w = 1'b0; u_b_h_w = 3'b010;
        s0 = store_cnt;
        n  = 0;
        while (store_cnt == s0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_fill_reached", 32'(store_cnt - s0), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_invalid", 32'(cache_invalid), 32'd1);
        check_eq("mid_rst_set_addr", cache_addr, 32'h040);
        check_eq("mid_rst_cs", 32'(mem_cs_o), 32'd0);
        check_eq("mid_rst_stall", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        check_eq("rst2_invalid", 32'(cache_invalid), 32'd0);
        check_eq("rst2_cs", 32'(mem_cs_o), 32'd0);
        check_eq("rst2_stall", 32'(stall), 32'd1);
        check_eq("rst2_data_r", data_r, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        en_r = 1'b0;
        #1;
        check_eq("post_rst_stall", 32'(stall), 32'd0);
        check_eq("post_rst_cs", 32'(mem_cs_o), 32'd0);
        cpu_access(32'h044, 1'b1, 1'b0, 3'b010, 32'h0, cyc, e0, l0);
        check_eq("post_rst_refill_cyc", 32'(cyc), 32'd20);
        check_eq("post_rst_data", data_r, 32'hC000_0044);

        check_eq("strobe_exclusive", 32'(excl_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
